spi_flash_read_seq: RTL and testbench
=====================================

# spi_flash_read_seq

Read sequencer for the on-board SPI flash (SPIFlashCEJ/SCK/SI/SO/WPJ pins of the platform top). It accepts one read request (24-bit address, byte count), issues the standard READ command (0x03) in SPI mode 0, and streams the returned bytes out over a valid/ready interface. Downstream backpressure stalls the serial clock. The block sits between the SoC bus/boot logic and the flash pins.

## Interface
- CLK_DIV, 2: SCK half-period in clk_i cycles; legal range ≥1. Bit period = 2*CLK_DIV cycles.
- LEN_W, 16: width of the byte-count field.
- GAP_BITS, 4: minimum CEJ-high time between transactions, in bit periods.

- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready; high only in IDLE
- req_addr_i  in  24  flash byte address
- req_len_i  in  LEN_W  bytes to read minus one (0 = 1 byte)
- rd_data_o  out  8  read byte
- rd_valid_o  out  1  rd_data_o valid
- rd_ready_i  in  1  consumer accepts byte
- rd_last_o  out  1  qualifies the final byte of a request
- busy_o  out  1  high from accept until the end of GAP
- spi_cej  out  1  flash chip select, active low
- spi_sck  out  1  serial clock; idles low
- spi_si  out  1  MOSI
- spi_so  in  1  MISO
- spi_wpj  out  1  write protect; constant 1

## Operation
- States: IDLE, CMD (8 bits), ADDR (24 bits), DATA, STALL, CS_HOLD, GAP.
- IDLE: req_ready_o=1. When req_valid_i&&req_ready_o, the block latches the address and length, loads the 32-bit shift word {0x03, addr}, and goes to CMD.
- Bit period: a low phase of CLK_DIV cycles, then a high phase of CLK_DIV cycles. spi_si changes only at the start of a low phase, MSB first. spi_so is captured on the clk edge that drives spi_sck high.
- CMD → ADDR → DATA transitions are seamless, with no extra cycles. During DATA, spi_si is driven to 0.
- DATA: bits shift into an 8-bit register.
  - After the 8th high phase ends, the byte goes to the output register if that register is empty or is being consumed this cycle (rd_valid_o&&rd_ready_i).
  - If the output register is full and not being consumed, the block enters STALL. spi_sck is held low and no bit starts until the load happens.
- The byte counter decrements on each load. When the last byte is loaded, rd_last_o=1 with it and the next state is CS_HOLD.
- CS_HOLD: CLK_DIV cycles with spi_sck low. Then spi_cej goes to 1 and the state moves to GAP.
- GAP: GAP_BITS*2*CLK_DIV cycles. Then IDLE.
- Output register: rd_valid_o stays high until rd_ready_i. rd_data_o and rd_last_o are stable while rd_valid_o && !rd_ready_i.
- A new request is accepted only in IDLE. The last byte may still be pending in the output register at that point; this is legal.
- Address wrap at the top of the flash is the device's concern; the block does no address arithmetic.
- Counter width is LEN_W+1 bits, so req_len_i = all-ones yields 2^LEN_W bytes with no overflow.

## Timing
- Reset values (and the outcome of rst_i asserted mid-transaction, effective the next cycle): spi_cej=1, spi_sck=0, spi_si=0, spi_wpj=1, rd_valid_o=0, rd_last_o=0, rd_data_o=0, busy_o=0, state IDLE. The pending byte is discarded. No further SCK edges occur.
- Requests presented while rst_i is high are ignored.
- Accept at cycle 0:
  - spi_cej=0 and busy_o=1 at cycle 1.
  - The first spi_sck rise is at cycle 1+CLK_DIV.
  - Bit k rises at 1+CLK_DIV+2k*CLK_DIV, for k=0..39 in the first byte.
- First rd_valid_o=1 at cycle 1+80*CLK_DIV (161 for CLK_DIV=2).
- Unstalled byte-to-byte spacing is 16*CLK_DIV cycles.
- After the last byte loads:
  - spi_cej=1 after CLK_DIV cycles.
  - req_ready_o returns after a further GAP_BITS*2*CLK_DIV cycles.
- spi_cej never toggles while spi_sck=1. spi_sck high pulse width is always exactly CLK_DIV cycles.

## Test plan
- CLK_DIV=2, addr 0x012345, len 0: spi_si carries 0x03,0x01,0x23,0x45 MSB-first; flash model returns 0xA5; rd_data_o=0xA5 with rd_last_o=1 at cycle 161; spi_cej high at 163; req_ready_o at 179.
- len 3, rd_ready_i=1, model returns 0x10..0x13: four bytes in order, spaced 32 cycles apart; rd_last_o set only on 0x13; exactly 64 SCK rises total.
- Backpressure: len 2, rd_ready_i=0 for 100 cycles after the first byte: SCK stays low during STALL, no bytes are lost, and the data order is intact after release.
- rst_i pulsed during ADDR bit 10: the next cycle shows spi_cej=1, spi_sck=0, rd_valid_o=0; a fresh request afterwards completes normally.
- req_valid_i held high continuously for back-to-back requests: the second accept occurs only after GAP; spi_cej is high for ≥16 cycles between transactions.
- CLK_DIV=1 with len 0xFFFF: 65536 bytes delivered, the counter does not wrap early, and rd_last_o appears exactly once.

Source files
------------

// File: rtl/spi_flash_read_seq.sv
// SPI flash read sequencer: issues READ (0x03) plus a 24-bit address in SPI mode 0
// and streams the returned bytes over valid/ready, stalling SCK under backpressure.
module spi_flash_read_seq #(
    parameter int CLK_DIV  = 2,
    parameter int LEN_W    = 16,
    parameter int GAP_BITS = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [23:0]      req_addr_i,
    input  logic [LEN_W-1:0] req_len_i,
    output logic [7:0]       rd_data_o,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic             rd_last_o,
    output logic             busy_o,
    output logic             spi_cej,
    output logic             spi_sck,
    output logic             spi_si,
    input  logic             spi_so,
    output logic             spi_wpj
);
    localparam int GAP_CYC = GAP_BITS * 2 * CLK_DIV;
    localparam int TMR_W   = $clog2(GAP_CYC + CLK_DIV + 1);
    localparam logic [TMR_W-1:0] PH_LAST  = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [7:0]       READ_CMD = 8'h03;
    localparam logic [LEN_W:0]   CNT_ONE  = (LEN_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_STALL, S_CS_HOLD, S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             sck_q, sck_d;
    logic             cej_q, cej_d;
    logic             si_q, si_d;
    logic [30:0]      sh_q, sh_d;
    logic [4:0]       bit_q, bit_d;
    logic [7:0]       rx_q, rx_d;
    logic [LEN_W:0]   left_q, left_d;
    logic             vld_q, vld_d;
    logic [7:0]       data_q, data_d;
    logic             last_q, last_d;

    logic out_free;
    logic phase_end;
    logic load;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            sck_q   <= 1'b0;
            cej_q   <= 1'b1;
            si_q    <= 1'b0;
            sh_q    <= '0;
            bit_q   <= '0;
            rx_q    <= '0;
            left_q  <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            tmr_q   <= tmr_d;
            sck_q   <= sck_d;
            cej_q   <= cej_d;
            si_q    <= si_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            rx_q    <= rx_d;
            left_q  <= left_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        tmr_d     = tmr_q;
        sck_d     = sck_q;
        cej_d     = cej_q;
        si_d      = si_q;
        sh_d      = sh_q;
        bit_d     = bit_q;
        rx_d      = rx_q;
        left_d    = left_q;
        vld_d     = vld_q;
        data_d    = data_q;
        last_d    = last_q;
        load      = 1'b0;
        out_free  = !vld_q || rd_ready_i;
        phase_end = (tmr_q == PH_LAST);

        if (vld_q && rd_ready_i) begin
            vld_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_d = S_CMD;
                    cej_d   = 1'b0;
                    sck_d   = 1'b0;
                    tmr_d   = '0;
                    bit_d   = '0;
                    sh_d    = {READ_CMD[6:0], req_addr_i};
                    si_d    = READ_CMD[7];
                    left_d  = {1'b0, req_len_i} + CNT_ONE;
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                tmr_d = tmr_q + TMR_ONE;
                if (phase_end) begin
                    tmr_d = '0;
                    if (!sck_q) begin
                        // MISO is sampled on the edge that raises SCK.
                        sck_d = 1'b1;
                        if (state_q == S_DATA) begin
                            rx_d = {rx_q[6:0], spi_so};
                        end
                    end else begin
                        sck_d = 1'b0;
                        bit_d = bit_q + 5'd1;
                        if (state_q != S_DATA) begin
                            sh_d = {sh_q[29:0], 1'b0};
                            si_d = sh_q[30];
                            if (bit_q == 5'd7) begin
                                state_d = S_ADDR;
                            end
                            if (bit_q == 5'd31) begin
                                state_d = S_DATA;
                                si_d    = 1'b0;
                                bit_d   = '0;
                            end
                        end else if (bit_q == 5'd7) begin
                            bit_d = '0;
                            if (out_free) begin
                                load = 1'b1;
                            end else begin
                                state_d = S_STALL;
                            end
                        end
                    end
                end
            end
            S_STALL: begin
                if (out_free) begin
                    load = 1'b1;
                end
            end
            S_CS_HOLD: begin
                tmr_d = tmr_q + TMR_ONE;
                if (phase_end) begin
                    tmr_d   = '0;
                    cej_d   = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                tmr_d = tmr_q + TMR_ONE;
                if (tmr_q == GAP_LAST) begin
                    tmr_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A completed byte moves into the output register; the next bit starts fresh.
        if (load) begin
            vld_d   = 1'b1;
            data_d  = rx_q;
            last_d  = (left_q == CNT_ONE);
            left_d  = left_q - CNT_ONE;
            tmr_d   = '0;
            state_d = (left_q == CNT_ONE) ? S_CS_HOLD : S_DATA;
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign rd_data_o   = data_q;
    assign rd_valid_o  = vld_q;
    assign rd_last_o   = last_q;
    assign spi_cej     = cej_q;
    assign spi_sck     = sck_q;
    assign spi_si      = si_q;
    assign spi_wpj     = 1'b1;

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Directed bench for spi_flash_read_seq with a mode-0 SPI flash model whose read data
// is base+byte_index; the all-ones length case uses a second instance with LEN_W=8, CLK_DIV=1.
module tb_spi_flash_read_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, rd_ready, sel;
    logic [23:0] req_addr;
    logic [15:0] req_len;
    logic        spi_so = 1'b0;

    logic       rdy0, vld0, last0, busy0, cej0, sck0, si0, wpj0;
    logic [7:0] data0;
    logic       rdy1, vld1, last1, busy1, cej1, sck1, si1, wpj1;
    logic [7:0] data1;

    spi_flash_read_seq #(.CLK_DIV(2), .LEN_W(16), .GAP_BITS(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid && !sel), .req_ready_o(rdy0),
        .req_addr_i(req_addr), .req_len_i(req_len),
        .rd_data_o(data0), .rd_valid_o(vld0), .rd_ready_i(rd_ready),
        .rd_last_o(last0), .busy_o(busy0),
        .spi_cej(cej0), .spi_sck(sck0), .spi_si(si0), .spi_so(spi_so), .spi_wpj(wpj0)
    );

    spi_flash_read_seq #(.CLK_DIV(1), .LEN_W(8), .GAP_BITS(4)) dut_fast (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid && sel), .req_ready_o(rdy1),
        .req_addr_i(req_addr), .req_len_i(req_len[7:0]),
        .rd_data_o(data1), .rd_valid_o(vld1), .rd_ready_i(rd_ready),
        .rd_last_o(last1), .busy_o(busy1),
        .spi_cej(cej1), .spi_sck(sck1), .spi_si(si1), .spi_so(spi_so), .spi_wpj(wpj1)
    );

    logic       m_ready, m_valid, m_last, m_busy, m_cej, m_sck, m_si, m_wpj;
    logic [7:0] m_data;
    assign m_ready = sel ? rdy1  : rdy0;
    assign m_valid = sel ? vld1  : vld0;
    assign m_last  = sel ? last1 : last0;
    assign m_busy  = sel ? busy1 : busy0;
    assign m_cej   = sel ? cej1  : cej0;
    assign m_sck   = sel ? sck1  : sck0;
    assign m_si    = sel ? si1   : si0;
    assign m_wpj   = sel ? wpj1  : wpj0;
    assign m_data  = sel ? data1 : data0;

    // Flash model: shifts in SI on SCK rise, drives SO on SCK fall once 32 bits are in.
    int          fl_bits   = 0;
    int          sck_rises = 0;
    logic [31:0] fl_word   = '0;
    logic [7:0]  fl_base   = '0;
    logic [7:0]  fl_byte;

    always @(negedge m_cej or posedge m_sck) begin
        if (!m_sck) begin
            fl_bits = 0;
            fl_word = '0;
        end else begin
            if (!m_cej) begin
                if (fl_bits < 32) fl_word = {fl_word[30:0], m_si};
                fl_bits++;
            end
            sck_rises++;
        end
    end

    always @(negedge m_sck) begin
        if (!m_cej && fl_bits >= 32) begin
            fl_byte = fl_base + 8'((fl_bits - 32) / 8);
            spi_so  = fl_byte[7 - ((fl_bits - 32) % 8)];
        end
    end

    int checks = 0;
    int errors = 0;
    int cur, sck_base;
    int got_n, seq_bad, last_cnt, last_idx, hold_bad, win_hi_cnt;
    int got_cyc[4];
    logic done;
    int n_acc, cej_hi, nbytes;
    int acc_cyc[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int n);
        while (cur < n) begin
            @(negedge clk);
            cur++;
        end
    endtask

    // Called on a negedge; afterwards cur=1 is the first cycle after the accept edge.
    task automatic start_req(input logic [23:0] a, input int len, input logic [7:0] b);
        check("ready_before_req", 32'(m_ready), 32'h1);
        req_addr  = a;
        req_len   = 16'(len);
        fl_base   = b;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        cur       = 1;
        sck_base  = sck_rises;
    endtask

    // Consumes bytes until req_ready_o returns; rd_ready is low for cycles st_lo..st_hi.
    task automatic collect(input int budget, input int st_lo, input int st_hi,
                           input int w_lo, input int w_hi);
        logic       prev_hold;
        logic [7:0] prev_data;
        logic       prev_last;
        got_n = 0; seq_bad = 0; last_cnt = 0; last_idx = -1; hold_bad = 0; win_hi_cnt = 0;
        done = 1'b0; prev_hold = 1'b0; prev_data = '0; prev_last = 1'b0;
        while (!done && cur < budget) begin
            rd_ready = !(cur >= st_lo && cur <= st_hi);
            if (m_valid) begin
                if (prev_hold && (m_data !== prev_data || m_last !== prev_last)) hold_bad++;
                if (rd_ready) begin
                    if (m_data !== 8'(fl_base + 8'(got_n))) seq_bad++;
                    if (got_n < 4) got_cyc[got_n] = cur;
                    if (m_last) begin
                        last_cnt++;
                        last_idx = got_n;
                    end
                    got_n++;
                end
            end
            if (cur >= w_lo && cur <= w_hi && m_sck) win_hi_cnt++;
            prev_hold = m_valid && !rd_ready;
            prev_data = m_data;
            prev_last = m_last;
            if (m_ready) done = 1'b1;
            else begin
                @(negedge clk);
                cur++;
            end
        end
        rd_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; rd_ready = 1'b1; sel = 1'b0;
        req_addr = '0; req_len = '0; cur = 0;
        repeat (3) @(negedge clk);

        check("rst_cej",   32'(m_cej),   32'h1);
        check("rst_sck",   32'(m_sck),   32'h0);
        check("rst_si",    32'(m_si),    32'h0);
        check("rst_wpj",   32'(m_wpj),   32'h1);
        check("rst_valid", 32'(m_valid), 32'h0);
        check("rst_last",  32'(m_last),  32'h0);
        check("rst_data",  32'(m_data),  32'h0);
        check("rst_busy",  32'(m_busy),  32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte read, cycle-exact timing.
        start_req(24'h012345, 0, 8'hA5);
        check("t1_cej_c1",   32'(m_cej),   32'h0);
        check("t1_busy_c1",  32'(m_busy),  32'h1);
        check("t1_ready_c1", 32'(m_ready), 32'h0);
        goto(2);   check("t1_sck_c2", 32'(m_sck), 32'h0);
        goto(3);   check("t1_sck_c3", 32'(m_sck), 32'h1);
        goto(4);   check("t1_sck_c4", 32'(m_sck), 32'h1);
        goto(5);   check("t1_sck_c5", 32'(m_sck), 32'h0);
        goto(160); check("t1_valid_c160", 32'(m_valid), 32'h0);
        goto(161);
        check("t1_valid_c161", 32'(m_valid), 32'h1);
        check("t1_data_c161",  32'(m_data),  32'hA5);
        check("t1_last_c161",  32'(m_last),  32'h1);
        goto(162);
        check("t1_cej_c162",   32'(m_cej),   32'h0);
        check("t1_valid_c162", 32'(m_valid), 32'h0);
        goto(163); check("t1_cej_c163",   32'(m_cej),   32'h1);
        goto(178); check("t1_ready_c178", 32'(m_ready), 32'h0);
        goto(179);
        check("t1_ready_c179", 32'(m_ready), 32'h1);
        check("t1_busy_c179",  32'(m_busy),  32'h0);
        check("t1_si_word",    fl_word,      32'h03012345);
        check("t1_sck_rises",  32'(sck_rises - sck_base), 32'd40);

        // Four bytes, no backpressure.
        start_req(24'h100000, 3, 8'h10);
        collect(1000, 1, 0, 1, 0);
        check("t2_done",      32'(done),     32'h1);
        check("t2_end_cycle", 32'(cur),      32'd275);
        check("t2_count",     32'(got_n),    32'd4);
        check("t2_order",     32'(seq_bad),  32'd0);
        check("t2_last_cnt",  32'(last_cnt), 32'd1);
        check("t2_last_idx",  32'(last_idx), 32'd3);
        check("t2_first_cyc", 32'(got_cyc[0]), 32'd161);
        check("t2_spacing",   32'(got_cyc[1] - got_cyc[0]), 32'd32);
        check("t2_fourth_cyc", 32'(got_cyc[3]), 32'd257);
        check("t2_sck_rises", 32'(sck_rises - sck_base), 32'd64);
        check("t2_si_word",   fl_word, 32'h03100000);

        // Three bytes with rd_ready low for 100 cycles after the first byte.
        start_req(24'h0A0B0C, 2, 8'h30);
        collect(1000, 162, 261, 225, 262);
        check("t3_done",       32'(done),       32'h1);
        check("t3_count",      32'(got_n),      32'd3);
        check("t3_order",      32'(seq_bad),    32'd0);
        check("t3_hold",       32'(hold_bad),   32'd0);
        check("t3_last_idx",   32'(last_idx),   32'd2);
        check("t3_cyc1",       32'(got_cyc[1]), 32'd262);
        check("t3_cyc2",       32'(got_cyc[2]), 32'd263);
        check("t3_stall_sck",  32'(win_hi_cnt), 32'd0);
        check("t3_sck_rises",  32'(sck_rises - sck_base), 32'd56);
        check("t3_end_cycle",  32'(cur),        32'd281);

        // Reset during ADDR bit 10 (rises at cycle 75), request during reset ignored.
        start_req(24'h111111, 0, 8'h77);
        goto(75);
        rst = 1'b1;
        goto(76);
        check("t4_cej",   32'(m_cej),   32'h1);
        check("t4_sck",   32'(m_sck),   32'h0);
        check("t4_valid", 32'(m_valid), 32'h0);
        check("t4_busy",  32'(m_busy),  32'h0);
        req_valid = 1'b1;
        goto(77);
        rst = 1'b0;
        req_valid = 1'b0;
        check("t4_ign_cej",  32'(m_cej),  32'h1);
        check("t4_ign_busy", 32'(m_busy), 32'h0);
        sck_base = sck_rises;
        goto(97);
        check("t4_no_sck", 32'(sck_rises - sck_base), 32'd0);
        start_req(24'hABCDEF, 1, 8'h5A);
        collect(1000, 1, 0, 1, 0);
        check("t4_done",      32'(done),     32'h1);
        check("t4_count",     32'(got_n),    32'd2);
        check("t4_order",     32'(seq_bad),  32'd0);
        check("t4_last_idx",  32'(last_idx), 32'd1);
        check("t4_si_word",   fl_word,       32'h03ABCDEF);
        check("t4_end_cycle", 32'(cur),      32'd211);

        // Back-to-back requests with req_valid held high.
        req_addr = 24'h0000AA; req_len = '0; fl_base = 8'hC3; req_valid = 1'b1;
        cur = 0; n_acc = 0; cej_hi = 0; nbytes = 0; acc_cyc[0] = -1; acc_cyc[1] = -1;
        sck_base = sck_rises;
        while (cur < 600 && !(n_acc == 2 && m_ready && cur > acc_cyc[1])) begin
            if (n_acc == 2) req_valid = 1'b0;
            if (n_acc == 1 && m_cej) cej_hi++;
            if (m_valid && rd_ready) nbytes++;
            if (m_ready && req_valid && n_acc < 2) begin
                acc_cyc[n_acc] = cur;
                n_acc++;
            end
            @(negedge clk);
            cur++;
        end
        req_valid = 1'b0;
        check("t5_accepts",   32'(n_acc),      32'd2);
        check("t5_acc0",      32'(acc_cyc[0]), 32'd0);
        check("t5_acc1",      32'(acc_cyc[1]), 32'd179);
        check("t5_cej_high",  32'(cej_hi),     32'd17);
        check("t5_bytes",     32'(nbytes),     32'd2);
        check("t5_end_cycle", 32'(cur),        32'd358);
        check("t5_sck_rises", 32'(sck_rises - sck_base), 32'd80);
        check("t5_si_word",   fl_word,         32'h030000AA);

        // All-ones length on the LEN_W=8, CLK_DIV=1 instance: 256 bytes.
        sel = 1'b1;
        @(negedge clk);
        start_req(24'h000100, 255, 8'h00);
        collect(6000, 1, 0, 1, 0);
        check("t6_done",      32'(done),     32'h1);
        check("t6_count",     32'(got_n),    32'd256);
        check("t6_order",     32'(seq_bad),  32'd0);
        check("t6_last_cnt",  32'(last_cnt), 32'd1);
        check("t6_last_idx",  32'(last_idx), 32'd255);
        check("t6_first_cyc", 32'(got_cyc[0]), 32'd81);
        check("t6_spacing",   32'(got_cyc[1] - got_cyc[0]), 32'd16);
        check("t6_sck_rises", 32'(sck_rises - sck_base), 32'd2080);
        check("t6_end_cycle", 32'(cur),      32'd4170);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
